// File: rtl/om_pkg.sv
// Shared types and constants for the radix-2 online multiplier controller and datapath.
package om_pkg;

  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_BAD  = 2'b11;

  localparam int OM_N     = 12;
  localparam int OM_DELTA = 3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    FLUSH,
    DRAIN
  } om_state_e;

  // The illegal code is forwarded as zero so the datapath never sees it.
  function automatic logic [1:0] sd_sanitize(input logic [1:0] d);
    return (d == SD_BAD) ? SD_ZERO : d;
  endfunction

endpackage

// File: rtl/om_out_reg.sv
// Single-entry output holding stage: product digit valid/last with ready/valid backpressure.
module om_out_reg (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic last_i,
  input  logic ready_i,
  output logic valid_o,
  output logic last_o
);

  logic valid_q, valid_d;
  logic last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    // A new digit wins over a same-cycle accept, so valid stays high.
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign last_o  = valid_q & last_q;

endmodule

// File: rtl/online_mult_ctrl.sv
// Online multiplier sequencer: INIT/RUN/FLUSH/DRAIN stepping with in/out handshakes.
// Optional OM_CTRL_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module online_mult_ctrl
  import om_pkg::*;
#(
  parameter  int N     = OM_N,
  parameter  int DELTA = OM_DELTA,
  localparam int CW    = $clog2(N + DELTA + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    x_digit,
  input  logic [1:0]    y_digit,
  input  logic          out_ready,
  output logic [1:0]    x_app_digit,
  output logic [1:0]    y_app_digit,
  output logic          app_en,
  output logic          csa_en,
  output logic          res_clr,
  output logic          sel_en,
  output logic          out_valid,
  output logic          out_last,
  output logic [CW-1:0] step,
  output logic          busy,
  output logic          done,
  output logic          dig_err
`ifdef OM_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam logic [CW-1:0] K_INIT_END  = CW'(DELTA - 1);
  localparam logic [CW-1:0] K_RUN_END   = CW'(N - 1);
  localparam logic [CW-1:0] K_FLUSH_END = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] K_SEL       = CW'(DELTA);

  om_state_e     state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic          done_q, done_d;
  logic          dig_err_q, dig_err_d;

  logic          in_phase;
  logic          ostall;
  logic          fire;
  logic          last_step;

  assign ostall = out_valid & ~out_ready;

  always_comb begin
    in_phase = (state_q == INIT) || (state_q == RUN);
    fire     = 1'b0;
    if (in_phase) begin
      fire = in_valid & ~ostall;
    end else if (state_q == FLUSH) begin
      fire = ~ostall;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    done_d    = 1'b0;
    dig_err_d = dig_err_q;
    if (fire) begin
      k_d = k_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = INIT;
          k_d       = '0;
          dig_err_d = 1'b0;
        end
      end
      INIT:  if (fire && (k_q == K_INIT_END))  state_d = RUN;
      RUN:   if (fire && (k_q == K_RUN_END))   state_d = FLUSH;
      FLUSH: if (fire && (k_q == K_FLUSH_END)) state_d = DRAIN;
      DRAIN: begin
        // done occupies its own DRAIN cycle so a coincident start is still ignored.
        if (done_q) begin
          state_d = IDLE;
          k_d     = '0;
        end else if (out_valid && out_ready && out_last) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (in_phase && fire && ((x_digit == SD_BAD) || (y_digit == SD_BAD))) begin
      dig_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      done_q    <= 1'b0;
      dig_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      done_q    <= done_d;
      dig_err_q <= dig_err_d;
    end
  end

  assign in_ready    = in_phase & ~ostall;
  assign app_en      = fire;
  assign csa_en      = fire;
  assign res_clr     = fire & (k_q == '0);
  assign sel_en      = fire & (k_q >= K_SEL);
  assign x_app_digit = in_phase ? sd_sanitize(x_digit) : SD_ZERO;
  assign y_app_digit = in_phase ? sd_sanitize(y_digit) : SD_ZERO;
  assign step        = k_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign dig_err     = dig_err_q;
  assign last_step   = (k_q == K_FLUSH_END);

  om_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sel_en),
    .last_i  (last_step),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .last_o  (out_last)
  );

`ifdef OM_CTRL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if ((in_phase || (state_q == FLUSH)) && !fire && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/online_mult_ctrl.md
Name: online_mult_ctrl

Overview:
- Sequencer for the radix-2 online multiplier datapath: 4-to-2 carry-save residual adder, on-the-fly operand registers and digit selection.
- Accepts MSD-first signed digits of X and Y, one pair per step, over an in_valid/in_ready handshake.
- Steps the datapath through its online-delay, run and flush phases, and emits one product digit per step with out_valid/out_ready backpressure.
- Sits between the serial operand sources and the datapath; owns no arithmetic beyond digit gating.

Parameters:
- N, 12: digits per operand and per product; the datapath word is N+1 bits, so the default matches the 13-stage adder.
- DELTA, 3: online delay in steps; legal range 1..N-1.
- CW, $clog2(N+DELTA+1): step-counter width (derived localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin an operation; sampled only in IDLE.
- in_valid  in  1  x_digit/y_digit valid.
- in_ready  out  1  controller accepts the digit pair this cycle.
- x_digit  in  2  signed digit {pos,neg}: 10=+1, 01=-1, 00=0, 11 illegal.
- y_digit  in  2  same encoding as x_digit.
- out_ready  in  1  downstream accepts the product digit.
- x_app_digit  out  2  digit to append to the X register (00 during flush).
- y_app_digit  out  2  digit to append to the Y register (00 during flush).
- app_en  out  1  append/shift enable for the operand registers.
- csa_en  out  1  load enable for the Ws/Wc residual registers.
- res_clr  out  1  force residual and carry-ins (cin1/cin2) to 0 on this step.
- sel_en  out  1  digit-selection result valid; product digit registered by the datapath.
- out_valid  out  1  product digit available.
- out_last  out  1  qualifies the final product digit.
- step  out  CW  current step index k.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last digit is accepted downstream.
- dig_err  out  1  sticky: an illegal 11 digit was accepted; cleared on start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, k=0.
  - All outputs 0, including out_valid and dig_err.
- States and transitions:
  - IDLE: on start go to INIT with k=0; res_clr armed for the first step.
  - INIT (k<DELTA): consumes input only; no product digit. Moves to RUN when k reaches DELTA.
  - RUN (DELTA<=k<N): consumes input and produces output. Moves to FLUSH when k reaches N.
  - FLUSH (N<=k<N+DELTA): zero digits appended, no input consumed. Moves to DRAIN after step N+DELTA-1 fires.
  - DRAIN: waits for the last out_valid&out_ready, pulses done, returns to IDLE.
- Output stall: ostall = out_valid & ~out_ready.
- Step fire conditions:
  - INIT/RUN: in_valid & ~ostall.
  - FLUSH: ~ostall.
- On a fire:
  - app_en=1 and csa_en=1; k increments.
  - res_clr=1 only on k=0.
  - sel_en=1 when k>=DELTA.
- No fire: app_en, csa_en and sel_en are 0, and k and the datapath hold.
- in_ready = (state is INIT or RUN) & ~ostall. It is combinational and does not depend on in_valid.
- x_app_digit/y_app_digit:
  - Pass the inputs through in INIT/RUN.
  - Are 00 in FLUSH.
  - 11 is forwarded as 00 and sets dig_err.
- out_valid is registered:
  - Set the cycle after a fire with sel_en=1.
  - Cleared on out_ready when no new sel_en fire occurs in the same cycle.
  - Simultaneous accept and new digit: out_valid stays 1.
- out_last = out_valid & (the digit is product index N-1, i.e. from step N+DELTA-1).
- Latency:
  - First product digit: out_valid DELTA+1 cycles after the first accepted input, with no stalls.
  - An unstalled operation takes N+DELTA steps plus 2 cycles (DRAIN and done).
- Boundary conditions:
  - start while busy: ignored.
  - in_valid gaps: hold with no state change.
  - Reset mid-operation: immediate IDLE; the datapath is re-cleared by res_clr on the next start.
  - done and start in the same cycle: start is ignored because the controller is not yet in IDLE.

Optional Feature:
- Macro: OM_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Counts cycles in INIT/RUN/FLUSH with no fire.
  - Saturates at 0xFFFF; clears on start and on reset.
- Undefined: no port and no counter logic.

Decomposition:
- Package om_pkg:
  - Signed-digit encodings: SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00.
  - State enum: IDLE, INIT, RUN, FLUSH, DRAIN.
  - Default N and DELTA constants shared with the datapath.
- One sub-module, om_out_reg: the out_valid/out_last holding stage with the ready/valid logic, reusable by the future divider controller.

Test Plan:
- Smoke run (N=12, DELTA=3, start, in_valid held high, out_ready=1):
  - 12 input accepts, 15 fires.
  - res_clr only at k=0.
  - First out_valid 4 cycles after the first accept.
  - 12 output digits, out_last on the 12th, done 1 cycle after it.
- Input gaps (in_valid low for 2 cycles at k=5): app_en/csa_en low and step held at 5 for those cycles; total of 12 product digits unchanged.
- Backpressure (out_ready low for 3 cycles at product digit 2):
  - out_valid held, in_ready=0, no fire.
  - After release, digits resume in order with none lost or duplicated.
- Flush (inputs 10,01,00,... through k=11): x_app_digit/y_app_digit=00 for k=12..14; in_ready=0 in FLUSH.
- Illegal digit (x_digit=11 at k=4): forwarded as 00 and dig_err=1 until the next start; a start with only legal digits leaves it at 0.
- Reset (rst_n pulled low at k=7, mid-RUN): all outputs 0 asynchronously; the next start runs a full clean 15-step sequence.
